// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: pipelined instruction decoder with a two-entry output skid buffer.
// The combinational decode result is registered into the output stage. If the output
// stage is full and stalled, the result goes into the skid entry instead.
// Optional build macro: DECO_EXT_OPS_EN adds the I-ALU, LUI, AUIPC, JAL and JALR decodes.
// Without that macro, those opcodes are treated as illegal.
module instr_decode_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        fmt,
    output logic              rd_we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              branch,
    output logic              illegal,
    output logic [CNT_W-1:0]  ill_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef DECO_EXT_OPS_EN
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
`ifdef DECO_EXT_OPS_EN
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`endif
    localparam logic [2:0] FMT_NONE = 3'd7;

    // One fully decoded instruction, as carried through the output and skid stages.
    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   imm;
        logic [2:0]        fmt;
        logic              rd_we;
        logic              mem_rd;
        logic              mem_wr;
        logic              branch;
        logic              illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Widen a 32-bit two's-complement immediate to XLEN bits, replicating the sign.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    // Zero-pad a 5-bit register field to the configured index width.
    function automatic logic [REG_AW-1:0] ridx(input logic [4:0] f);
        return REG_AW'(f);
    endfunction

    // Full decode of one word. Fields that the format does not use stay at zero.
    function automatic bundle_t decode(input logic [31:0] w);
        bundle_t b;
        b        = '0;
        b.opcode = w[6:0];
        b.funct3 = w[14:12];
        b.funct7 = w[31:25];
        b.fmt    = FMT_NONE;
        case (w[6:0])
            OP_R: begin
                b.fmt   = FMT_R;
                b.rs1   = ridx(w[19:15]);
                b.rs2   = ridx(w[24:20]);
                b.rd    = ridx(w[11:7]);
                b.rd_we = 1'b1;
            end
            OP_LOAD: begin
                b.fmt    = FMT_I;
                b.rs1    = ridx(w[19:15]);
                b.rd     = ridx(w[11:7]);
                b.rd_we  = 1'b1;
                b.mem_rd = 1'b1;
                b.imm    = sext32({{20{w[31]}}, w[31:20]});
            end
            OP_STORE: begin
                b.fmt    = FMT_S;
                b.rs1    = ridx(w[19:15]);
                b.rs2    = ridx(w[24:20]);
                b.mem_wr = 1'b1;
                b.imm    = sext32({{20{w[31]}}, w[31:25], w[11:7]});
            end
            OP_BRANCH: begin
                b.fmt    = FMT_B;
                b.rs1    = ridx(w[19:15]);
                b.rs2    = ridx(w[24:20]);
                b.branch = 1'b1;
                b.imm    = sext32({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
            end
`ifdef DECO_EXT_OPS_EN
            OP_IALU: begin
                b.fmt   = FMT_I;
                b.rs1   = ridx(w[19:15]);
                b.rd    = ridx(w[11:7]);
                b.rd_we = 1'b1;
                b.imm   = sext32({{20{w[31]}}, w[31:20]});
            end
            OP_LUI, OP_AUIPC: begin
                b.fmt   = FMT_U;
                b.rd    = ridx(w[11:7]);
                b.rd_we = 1'b1;
                b.imm   = sext32({w[31:12], 12'b0});
            end
            OP_JAL: begin
                b.fmt    = FMT_J;
                b.rd     = ridx(w[11:7]);
                b.rd_we  = 1'b1;
                b.branch = 1'b1;
                b.imm    = sext32({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
            end
            OP_JALR: begin
                b.fmt    = FMT_I;
                b.rs1    = ridx(w[19:15]);
                b.rd     = ridx(w[11:7]);
                b.rd_we  = 1'b1;
                b.branch = 1'b1;
                b.imm    = sext32({{20{w[31]}}, w[31:20]});
            end
`endif
            default: begin
                b.illegal = 1'b1;
            end
        endcase
        return b;
    endfunction

    state_t            state, state_nxt;
    logic              xfer_in, xfer_out;
    logic              load_out, load_skid, load_from_skid;
    bundle_t           dec_p0;
    bundle_t           out_p1;
    bundle_t           skid_p1;
    logic [CNT_W-1:0]  ill_cnt;

    // ---- stage p0: combinational decode of the incoming word ----
    assign dec_p0    = decode(instr);

    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and stage-load selects, derived from the two handshakes.
    always_comb begin
        state_nxt      = state;
        load_out       = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer_in) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_out  = 1'b1;
                end else if (xfer_in) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (xfer_out) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (xfer_out) begin
                    state_nxt      = ONE;
                    load_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // ---- stage p1: output register, cleared on reset so outputs show the idle bundle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1     <= '0;
            out_p1.fmt <= FMT_NONE;
        end else if (load_out) begin
            out_p1     <= dec_p0;
        end else if (load_from_skid) begin
            out_p1     <= skid_p1;
        end
    end

    // ---- stage p1: skid entry, catches one word while the output register is stalled ----
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_p1 <= dec_p0;
        end
    end

    // Saturating count of illegal words accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_cnt <= '0;
        end else if (xfer_in && dec_p0.illegal && (ill_cnt != {CNT_W{1'b1}})) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

    assign rs1       = out_p1.rs1;
    assign rs2       = out_p1.rs2;
    assign rd        = out_p1.rd;
    assign opcode    = out_p1.opcode;
    assign funct3    = out_p1.funct3;
    assign funct7    = out_p1.funct7;
    assign imm       = out_p1.imm;
    assign fmt       = out_p1.fmt;
    assign rd_we     = out_p1.rd_we;
    assign mem_rd    = out_p1.mem_rd;
    assign mem_wr    = out_p1.mem_wr;
    assign branch    = out_p1.branch;
    assign illegal   = out_p1.illegal;
    assign ill_count = ill_cnt;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard testbench for instr_decode_pipe.
// Honours DECO_EXT_OPS_EN in its reference model, in the same way as the design.
module tb_instr_decode_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
`ifdef DECO_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       instr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              rd_we, mem_rd, mem_wr, branch, illegal;
    logic [CNT_W-1:0]  ill_count;

    int checks = 0;
    int errors = 0;
    int nout   = 0;

    bit rdy_mode  = 1'b0;
    bit rdy_force = 1'b1;
    bit rst_edge  = 1'b0;
    bit prev_rst  = 1'b0;
    int exp_cnt   = 0;
    logic [71:0] exp_q[$];

    instr_decode_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .rd(rd),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt),
        .rd_we(rd_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch),
        .illegal(illegal), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        we, mr, mw, br, ill;
    } exp_t;

    function automatic logic [71:0] pack(input exp_t e);
        return {e.rs1, e.rs2, e.rd, e.op, e.f3, e.f7, e.imm, e.fmt, e.we, e.mr, e.mw, e.br, e.ill};
    endfunction

    function automatic logic [71:0] act_vec();
        return {rs1, rs2, rd, opcode, funct3, funct7, imm, fmt, rd_we, mem_rd, mem_wr, branch, illegal};
    endfunction

    // Reference decode: immediates rebuilt from weighted field values, then wrapped to signed.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   v;
        int   opc;
        e     = '{default: '0};
        e.op  = w[6:0];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        e.fmt = 3'd7;
        opc   = int'(w[6:0]);
        v     = 0;
        if (opc == 'h33) begin
            e.fmt = 3'd0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.we = 1'b1;
        end else if (opc == 'h03) begin
            v = int'(w[31:20]); if (v >= 2048) v -= 4096;
            e.fmt = 3'd1; e.rs1 = w[19:15]; e.rd = w[11:7]; e.we = 1'b1; e.mr = 1'b1; e.imm = v;
        end else if (opc == 'h23) begin
            v = int'(w[31:25]) * 32 + int'(w[11:7]); if (v >= 2048) v -= 4096;
            e.fmt = 3'd2; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.mw = 1'b1; e.imm = v;
        end else if (opc == 'h63) begin
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            e.fmt = 3'd3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.br = 1'b1; e.imm = v;
        end else if (EXT && (opc == 'h13 || opc == 'h67)) begin
            v = int'(w[31:20]); if (v >= 2048) v -= 4096;
            e.fmt = 3'd1; e.rs1 = w[19:15]; e.rd = w[11:7]; e.we = 1'b1; e.imm = v;
            e.br = (opc == 'h67);
        end else if (EXT && (opc == 'h37 || opc == 'h17)) begin
            e.fmt = 3'd4; e.rd = w[11:7]; e.we = 1'b1; e.imm = w & 32'hFFFFF000;
        end else if (EXT && opc == 'h6F) begin
            v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * (1 << 11)
              + int'(w[30:21]) * 2;
            if (v >= (1 << 20)) v -= (1 << 21);
            e.fmt = 3'd5; e.rd = w[11:7]; e.we = 1'b1; e.br = 1'b1; e.imm = v;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [6:0]  ops [12];
        ops = '{7'h33, 7'h33, 7'h03, 7'h23, 7'h63, 7'h63, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        w = $urandom;
        ops[11] = w[6:0];
        w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        instr = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %h not accepted in 200 cycles", w);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Downstream ready: random or forced, updated shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    always @(posedge clk) rst_edge <= rst;

    // Monitor and scoreboard: compare deliveries, then record the word accepted this cycle.
    always @(negedge clk) begin
        exp_t r;
        if (rst) begin
            if (rst_edge) begin
                r = '{default: '0};
                r.fmt = 3'd7;
                check("rst_out_valid", 72'(out_valid), 72'(0));
                check("rst_in_ready", 72'(in_ready), 72'(0));
                check("rst_ill_count", 72'(ill_count), 72'(0));
                check("rst_bundle", act_vec(), pack(r));
            end
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (prev_rst) begin
                check("post_rst_in_ready", 72'(in_ready), 72'(1));
                check("post_rst_out_valid", 72'(out_valid), 72'(0));
            end
            check("ill_count", 72'(ill_count), 72'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bundle: got %h expected none", act_vec());
                end else begin
                    check($sformatf("bundle%0d", nout), act_vec(), exp_q.pop_front());
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                r = model(instr);
                exp_q.push_back(pack(r));
                if (r.ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
        end
        prev_rst = rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send(32'h002081B3);
        send(32'h0080A283);
        send(32'h0020A623);
        send(32'hFE20CEE3);
        send(32'h00000013);
        idle(3);
        check("addi_ill_count", 72'(ill_count), EXT ? 72'(0) : 72'(1));

        rdy_force = 1'b0;
        send(32'h00308233);
        send(32'h00412283);
        in_valid = 1'b1;
        instr = 32'h00520333;
        @(negedge clk);
        check("stall_in_ready", 72'(in_ready), 72'(0));
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        send(32'h00520333);
        idle(4);

        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_word());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        idle(4);

        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            w[6:0] = 7'h7F;
            send(w);
        end
        idle(3);
        check("ill_count_sat", 72'(ill_count), 72'(4'hF));

        rdy_force = 1'b0;
        send(rand_word());
        send(rand_word());
        check("two_in_ready", 72'(in_ready), 72'(0));
        check("two_out_valid", 72'(out_valid), 72'(1));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        rdy_force = 1'b1;
        idle(6);
        send(32'h002081B3);
        send(32'hFE20CEE3);
        idle(4);

        check("queue_empty", 72'(exp_q.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Parametrised, pipelined instruction decoder for the basic microprocessor. It sits between instruction fetch and the register file/ALU/memory stages. Each instruction word is accepted through a valid/ready handshake and split into register indices, opcode fields and a fully sign-extended immediate. Format and control flags are produced, and illegal encodings are flagged and counted. A two-entry output skid buffer gives full throughput under back-pressure.

## Interface
Parameters:
- XLEN, 32: immediate output width; must be ≥ 32.
- REG_AW, 5: register index width; fields are taken from instruction bits, and upper bits are zero-padded when REG_AW > 5.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder can accept a word this cycle.
- instr  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- rs1, rs2, rd  out  REG_AW each  register indices.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- imm  out  XLEN  sign-extended immediate.
- fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- rd_we  out  1  instruction writes rd.
- mem_rd, mem_wr, branch  out  1 each  class flags.
- illegal  out  1  unsupported opcode.
- ill_count  out  CNT_W  saturating count of illegal words accepted.

## Operation
- Transfer in: occurs when in_valid && in_ready. Transfer out: occurs when out_valid && out_ready.
- Decode is combinational on instr. The result is registered into the output stage, or into the skid entry when the output stage is occupied and stalled.
- Storage states: EMPTY (no bundle), ONE (output stage full), TWO (output and skid both full).
  - EMPTY→ONE on transfer in.
  - ONE→EMPTY on transfer out without transfer in.
  - ONE stays ONE on simultaneous in and out; the new bundle replaces the output stage.
  - ONE→TWO on transfer in without transfer out.
  - TWO→ONE on transfer out; the skid moves to the output stage.
- in_ready = !skid_full, registered; it is 0 in TWO. No transfer in is possible from TWO.
- Opcodes and resulting fields:
  - 0110011 (R): rs1, rs2, rd; rd_we=1; imm=0.
  - 0000011 (load, I): rs1, rd; rd_we=1; mem_rd=1; imm=sext(instr[31:20]).
  - 0100011 (store, S): rs1, rs2; mem_wr=1; imm=sext({instr[31:25],instr[11:7]}).
  - 1100011 (branch, B): rs1, rs2; branch=1; imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- Unused index fields are output as 0, never left stale.
- Any other opcode: illegal=1, fmt=7, all flags 0, indices 0, imm 0. The bundle is still delivered in order.
- ill_count increments on each transfer in of an illegal word and saturates at all-ones.

## Timing
- Latency: 1 cycle. A word accepted at edge N is on the outputs after edge N, provided the stage is empty or draining.
- Throughput: 1 word/cycle while out_ready=1.
- Back-pressure: when out_ready falls, at most one more word is absorbed into the skid entry. in_ready deasserts the cycle after the skid fills.
- Outputs hold stable while out_valid && !out_ready.
- Reset values, while rst=1 and on the first cycle after it:
  - out_valid=0, in_ready=0 during rst and 1 on the first cycle after it, skid empty.
  - All decoded outputs = 0, fmt=7, ill_count=0.
- Reset mid-operation discards both stored bundles without delivering them. Counts held before reset are not restored.

## Configuration
- DECO_EXT_OPS_EN defined adds these decodes:
  - 0010011 (I-ALU): rd_we=1, fmt=I.
  - 0110111 LUI and 0010111 AUIPC: fmt=U, imm={instr[31:12],12'b0} sign-extended, rd_we=1.
  - 1101111 JAL: fmt=J, imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), rd_we=1, branch=1.
  - 1100111 JALR: fmt=I, rd_we=1, branch=1.
- Without the macro, those opcodes are illegal and counted.

## Test plan
- Reset, then 0x002081B3 (add x3,x1,x2) → one cycle later: out_valid=1, rs1=1, rs2=2, rd=3, fmt=0, rd_we=1, imm=0.
- 0x0080A283 (lw x5,8(x1)) → rd=5, rs1=1, imm=8, mem_rd=1. Then 0x0020A623 (sw x2,12(x1)) → rs1=1, rs2=2, imm=12, mem_wr=1.
- 0xFE20CEE3 (blt x1,x2,-4) → funct3=4, branch=1, imm=0xFFFFFFFC, fmt=3.
- Hold out_ready=0 and stream 3 words → first two accepted, in_ready=0 on the third; release → words delivered in order, no loss or duplicate.
- 0x00000013 (addi): without the macro → illegal=1, ill_count=1; with DECO_EXT_OPS_EN → fmt=1, illegal=0. Preload ill_count to all-ones → it stays saturated.
- Assert rst while in state TWO → out_valid=0 and ill_count=0 next cycle, and no stale bundle is delivered afterwards.
